// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit pipeline load/store performed as two 16-bit external SRAM accesses
module sram_controller #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] data,
  output logic [31:0] mem_result,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata,
  output logic        sram_we_n
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [16:0]   word_idx;
  logic [31:0]   wdata_q;
  logic          op_write;
  logic          req;
  logic          last;

  assign req  = mem_read | mem_write;
  assign last = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Request is captured once in IDLE; pipeline inputs are don't-care afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_idx   <= '0;
      wdata_q    <= '0;
      op_write   <= 1'b0;
      mem_result <= '0;
    end else begin
      if (state == IDLE && req) begin
        word_idx <= address[18:2];
        wdata_q  <= data;
        op_write <= mem_write;
      end
      if (state == LOW && last && !op_write)
        mem_result[15:0] <= sram_rdata;
      if (state == HIGH && last && !op_write)
        mem_result[31:16] <= sram_rdata;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    ready      = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we_n  = 1'b1;
    case (state)
      IDLE: begin
        ready = !req;
        if (req) begin
          state_nx = LOW;
          cnt_nx   = '0;
        end
      end
      LOW: begin
        sram_addr = {word_idx, 1'b0};
        if (op_write) begin
          sram_wdata = wdata_q[15:0];
          sram_we_n  = 1'b0;
        end
        if (last) begin
          state_nx = HIGH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      HIGH: begin
        sram_addr = {word_idx, 1'b1};
        if (op_write) begin
          sram_wdata = wdata_q[31:16];
          sram_we_n  = 1'b0;
        end
        if (last) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DONE: begin
        ready    = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - scoreboard bench for sram_controller with a behavioural SRAM
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data = '0;
  logic [31:0] mem_result;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        sram_we_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] result;
    int          low_cycles;
  } res_t;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] wdata;
  } strobe_t;

  res_t    res_q[$];
  strobe_t wr_q[$];
  logic [31:0] last_result = '0;

  logic [15:0] sram_mem [0:262143];

  sram_controller #(.ACCESS_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .data(data), .mem_result(mem_result), .ready(ready),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  assign sram_rdata = sram_mem[sram_addr];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Write strobe monitor: every low sram_we_n cycle must match the next expected strobe.
  always @(negedge clk) begin
    if (!rst && sram_we_n == 1'b0) begin
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe addr=%h wdata=%h", sram_addr, sram_wdata);
      end else begin
        strobe_t s;
        s = wr_q.pop_front();
        check("strobe_addr", {14'b0, sram_addr}, {14'b0, s.addr});
        check("strobe_wdata", {16'b0, sram_wdata}, {16'b0, s.wdata});
      end
    end
  end

  // Completion monitor: ready returning high after a stall marks DONE.
  int low_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      low_cnt = 0;
    end else if (!ready) begin
      low_cnt++;
    end else if (low_cnt > 0) begin
      if (res_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done result=%h", mem_result);
      end else begin
        res_t r;
        r = res_q.pop_front();
        check("mem_result", mem_result, r.result);
        check("stall_cycles", low_cnt, r.low_cycles);
      end
      low_cnt = 0;
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rdval);
    res_t r;
    logic [17:0] base;
    base = {a[18:2], 1'b0};
    mem_read  = rd;
    mem_write = wr;
    address   = a;
    data      = d;
    if (wr) begin
      wr_q.push_back('{base, d[15:0]});
      wr_q.push_back('{base, d[15:0]});
      wr_q.push_back('{base | 18'd1, d[31:16]});
      wr_q.push_back('{base | 18'd1, d[31:16]});
    end else begin
      last_result = rdval;
    end
    r.result = last_result;
    r.low_cycles = 5;
    res_q.push_back(r);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL done_timeout ready=%b", ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic drop();
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) sram_mem[i] = 16'(i) ^ 16'h5a5a;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", {31'b0, ready}, 32'd1);
      check("idle_we_n", {31'b0, sram_we_n}, 32'd1);
      check("idle_result", mem_result, 32'd0);
    end
    @(posedge clk); #1;

    issue(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, '0);
    wait_done(); drop();
    repeat (2) @(posedge clk); #1;

    issue(1'b1, 1'b0, 32'h0000_0010, '0, 32'hDEAD_BEEF);
    wait_done(); drop();
    repeat (3) @(negedge clk);
    check("result_held", mem_result, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    issue(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, '0);
    wait_done(); drop();
    repeat (2) @(posedge clk); #1;
    check("both_lo_half", {16'b0, sram_mem[18'h10]}, 32'h5678);
    check("both_hi_half", {16'b0, sram_mem[18'h11]}, 32'h1234);

    // Back-to-back: the read is presented in the cycle right after DONE.
    issue(1'b0, 1'b1, 32'h0000_0004, 32'hA5A5_0001, '0);
    wait_done();
    issue(1'b1, 1'b0, 32'h8000_0004, '0, 32'hA5A5_0001);
    wait_done(); drop();
    repeat (2) @(posedge clk); #1;

    // Abort a write as soon as it enters HIGH: low half lands, high half never strobes.
    mem_write = 1'b1; address = 32'h0000_0004; data = 32'hBEEF_CAFE;
    wr_q.push_back('{18'h2, 16'hCAFE});
    wr_q.push_back('{18'h2, 16'hCAFE});
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    drop();
    #1;
    check("abort_we_n", {31'b0, sram_we_n}, 32'd1);
    check("abort_ready", {31'b0, ready}, 32'd1);
    check("abort_addr", {14'b0, sram_addr}, 32'd0);
    check("abort_result", mem_result, 32'd0);
    last_result = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    issue(1'b1, 1'b0, 32'h0000_0004, '0, 32'hA5A5_CAFE);
    wait_done(); drop();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("strobes_left", wr_q.size(), 32'd0);
    check("results_left", res_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Initiator-side memory access unit for the MEM stage: accepts the pipeline's single-cycle 32-bit `mem_read`/`mem_write` requests and performs them as two sequential 16-bit accesses on an external SRAM. It drives `ready` low for the duration of a transaction so the pipeline freezes, then returns the assembled 32-bit read result. It replaces the zero-latency data-memory array when the design targets off-chip SRAM.

## Interface
- `ACCESS_CYCLES`, 2, cycles each SRAM halfword phase is held (must be ≥1)
- `clk` input 1 system clock, all state on rising edge
- `rst` input 1 reset, asynchronous and active-high
- `mem_read` input 1 pipeline read request
- `mem_write` input 1 pipeline write request; wins if both asserted
- `address` input 32 byte address; word-aligned (bits [1:0] ignored)
- `data` input 32 write data
- `mem_result` output 32 registered read result
- `ready` output 1 high = pipeline may advance; low = freeze
- `sram_addr` output 18 SRAM halfword address
- `sram_wdata` output 16 SRAM write data
- `sram_rdata` input 16 SRAM read data, valid while `sram_addr` held
- `sram_we_n` output 1 SRAM write enable, active-low

## Operation
- States: IDLE, LOW, HIGH, DONE. Phase counter `cnt` counts 0..ACCESS_CYCLES-1 inside LOW and HIGH.
- IDLE: if `mem_read|mem_write`, capture `address[18:2]` as word index, `data`, and op (write if `mem_write`); go to LOW, `cnt`=0. Otherwise stay.
- LOW: `sram_addr`={word_index,1'b0}; write: `sram_wdata`=data[15:0], `sram_we_n`=0. On `cnt`==ACCESS_CYCLES-1: read op latches `sram_rdata` into `mem_result[15:0]`; go to HIGH, `cnt`=0; else `cnt`++.
- HIGH: `sram_addr`={word_index,1'b1}; write: `sram_wdata`=data[31:16], `sram_we_n`=0. On last count: read op latches `sram_rdata` into `mem_result[31:16]`; go to DONE.
- DONE: one cycle; go to IDLE unconditionally.
- `ready` (combinational) = (state==IDLE & !(mem_read|mem_write)) | (state==DONE).
- IDLE/DONE: `sram_addr`=0, `sram_wdata`=0, `sram_we_n`=1. Reads always drive `sram_we_n`=1 and `sram_wdata`=0.
- Pipeline inputs are ignored outside IDLE; captured copies used for the whole transaction.
- `mem_result` holds its value until the next read overwrites it; writes never modify it.
- Address bits [31:19] are discarded (wrap-around within 128K words).

## Timing
- Reset (async, immediate): state IDLE, `cnt`=0, `mem_result`=0, captured regs=0, `sram_we_n`=1, `sram_addr`=0, `sram_wdata`=0; `ready`=1 if no request asserted.
- Request seen in IDLE at cycle 0 (`ready`=0 that cycle). LOW cycles 1..N, HIGH cycles N+1..2N, DONE cycle 2N+1 with `ready`=1 and `mem_result` final (N=ACCESS_CYCLES). Default: `ready` low 5 cycles, high on 6th.
- Low half of `mem_result` updates at end of cycle N, high half at end of cycle 2N.
- Request still asserted in IDLE after DONE is treated as a new request (pipeline advanced on the DONE edge).
- Back-to-back requests: one IDLE cycle between transactions (period 2N+2).
- Reset mid-transaction: abort at once, no further SRAM strobes; a partially written word stays partially written.
- Idle with no request: no SRAM activity, `ready`=1 continuously.

## Test plan
- Reset then idle: `rst` pulse, no requests for 10 cycles -> `ready`=1, `sram_we_n`=1, `mem_result`=0 throughout.
- Write 0xDEADBEEF to address 0x0000_0010 (N=2) -> `sram_we_n`=0 cycles 1–4; `sram_addr`=0x8/`sram_wdata`=0xBEEF cycles 1–2, `sram_addr`=0x9/`sram_wdata`=0xDEAD cycles 3–4; `ready`=1 only at cycle 5.
- Read back 0x10 from SRAM model -> `mem_result`=0xDEADBEEF at DONE, `sram_we_n` never low, value held after `mem_read` drops.
- Both `mem_read` and `mem_write` at 0x20 with data 0x12345678 -> write performed (halfwords 0x5678 at 0x10, 0x1234 at 0x11), `mem_result` unchanged.
- Back-to-back: write 0xA5A5_0001 @0x4 then read @0x4 held continuously -> second transaction starts the cycle after DONE; read returns 0xA5A50001; address 0x8000_0004 aliases to `sram_addr`=0x2/0x3.
- Assert `rst` during HIGH of a write -> `sram_we_n`=1 and state IDLE in same cycle; later read returns new low half, old high half.
